// File: rtl/busca_instrucao_pkg.sv
// busca_instrucao_pkg
// Shared constants and types for the instruction fetch stage:
//   WORD_W   - PC / instruction width
//   CNT_W    - width of the handed-to-decode instruction counter
//   estado_t - fetch FSM state encoding
package busca_instrucao_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } estado_t;

endpackage

// File: rtl/busca_instrucao.sv
// busca_instrucao
// Instruction fetch stage. Requests one word at a time from instruction
// memory at pc_atual, holds it for decode until accepted, and tells the PC
// register mux when to advance.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   pc_atual            current word address from the PC register
//   halt                processor halted: no new fetch is started
//   redirect            branch/jump/context switch: flush the stage
//   mem_req, mem_addr   instruction memory read request / word address
//   mem_ack, mem_rdata  read data valid / instruction word
//   instr_valid, instr, instr_pc   instruction handed to decode
//   decode_ready        decode accepts instr this cycle
//   novo_pc_seq         sequential next-PC candidate (pc_atual+1 on a fetch)
//   instr_count         number of instructions accepted by decode
module busca_instrucao
   import busca_instrucao_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] pc_atual,
   input  logic              halt,
   input  logic              redirect,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] instr_pc,
   input  logic              decode_ready,
   output logic [WORD_W-1:0] novo_pc_seq,
   output logic [CNT_W-1:0]  instr_count
);

   estado_t estado, proxEstado;
   logic    capturaInstr;   // fetch completes this cycle
   logic    handshake;      // decode takes the held instruction this cycle

   // State register; reset lands in REQ so the first fetch goes out as soon
   // as reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= REQ;
      else       estado <= proxEstado;
   end

   always_comb begin
      proxEstado   = estado;
      mem_req      = 1'b0;
      instr_valid  = 1'b0;
      capturaInstr = 1'b0;
      handshake    = 1'b0;

      case (estado)
         IDLE: begin
            if (!halt) proxEstado = REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            // A completing fetch wins over halt; halt then takes effect
            // once decode has taken the instruction.
            if (mem_ack && !redirect) begin
               capturaInstr = 1'b1;
               proxEstado   = VALID;
            end else if (halt) begin
               proxEstado = IDLE;
            end
         end
         VALID: begin
            // A redirect kills the held instruction in the same cycle so
            // decode never sees a handshake on a flushed word.
            instr_valid = !redirect;
            if (decode_ready && !redirect) begin
               handshake  = 1'b1;
               proxEstado = halt ? IDLE : REQ;
            end
         end
         default: proxEstado = REQ;
      endcase

      // Flush has priority in every state; any ack in this cycle is dropped.
      if (redirect) proxEstado = halt ? IDLE : REQ;
   end

   assign mem_addr    = pc_atual;
   assign novo_pc_seq = capturaInstr ? pc_atual + 1'b1 : pc_atual;

   // Instruction holding register, stable for the whole VALID period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr    <= '0;
         instr_pc <= '0;
      end else if (capturaInstr) begin
         instr    <= mem_rdata;
         instr_pc <= pc_atual;
      end
   end

   // Wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          instr_count <= '0;
      else if (handshake) instr_count <= instr_count + 1'b1;
   end

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_atual = '0;
   logic        halt = 1'b0;
   logic        redirect = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        decode_ready = 1'b0;
   logic [31:0] novo_pc_seq;
   logic [15:0] instr_count;

   int nChecks = 0;
   int nFail   = 0;

   busca_instrucao dut (
      .clk          (clk),
      .reset        (reset),
      .pc_atual     (pc_atual),
      .halt         (halt),
      .redirect     (redirect),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .decode_ready (decode_ready),
      .novo_pc_seq  (novo_pc_seq),
      .instr_count  (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        hlt, rdr, ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        eReq, eVal;
      logic [31:0] eNovo, eInstr, eIpc;
      logic [15:0] eCnt;
   } vec_t;

   vec_t vt [19];

   function automatic vec_t mk(input logic [31:0] pc, input logic hlt, rdr, ack,
                               input logic [31:0] rdata, input logic rdy,
                               input logic eReq, eVal, input logic [31:0] eNovo,
                               eInstr, eIpc, input logic [15:0] eCnt);
      vec_t v;
      v.pc = pc; v.hlt = hlt; v.rdr = rdr; v.ack = ack; v.rdata = rdata;
      v.rdy = rdy; v.eReq = eReq; v.eVal = eVal; v.eNovo = eNovo;
      v.eInstr = eInstr; v.eIpc = eIpc; v.eCnt = eCnt;
      return v;
   endfunction

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nome, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic hlt, rdr, ack,
                        input logic [31:0] rdata, input logic rdy);
      pc_atual = pc; halt = hlt; redirect = rdr; mem_ack = ack;
      mem_rdata = rdata; decode_ready = rdy;
      #1;
   endtask

   initial begin
      //              pc  h  r  a  rdata         rdy  req val novo instr         ipc cnt
      vt[0]  = mk(  0, 0, 0, 1, 32'h11110000, 1,  1, 0,  1, 32'h0,        0, 0);
      vt[1]  = mk(  1, 0, 0, 1, 32'h11110001, 1,  0, 1,  1, 32'h11110000, 0, 0);
      vt[2]  = mk(  1, 0, 0, 1, 32'h11110001, 1,  1, 0,  2, 32'h11110000, 0, 1);
      vt[3]  = mk(  2, 0, 0, 1, 32'h11110002, 1,  0, 1,  2, 32'h11110001, 1, 1);
      vt[4]  = mk(  2, 0, 0, 1, 32'h11110002, 1,  1, 0,  3, 32'h11110001, 1, 2);
      vt[5]  = mk(  3, 0, 0, 1, 32'h11110003, 1,  0, 1,  3, 32'h11110002, 2, 2);
      // redirect coinciding with ack at pc 20: data dropped, PC holds
      vt[6]  = mk( 20, 0, 1, 1, 32'hDEADBEEF, 1,  1, 0, 20, 32'h11110002, 2, 3);
      vt[7]  = mk( 20, 0, 0, 0, 32'h0,        0,  1, 0, 20, 32'h11110002, 2, 3);
      // halt in REQ without ack abandons the request; decode_ready ignored in IDLE
      vt[8]  = mk( 20, 1, 0, 0, 32'h0,        0,  1, 0, 20, 32'h11110002, 2, 3);
      vt[9]  = mk( 20, 1, 0, 0, 32'h0,        0,  0, 0, 20, 32'h11110002, 2, 3);
      vt[10] = mk( 20, 0, 0, 0, 32'h0,        1,  0, 0, 20, 32'h11110002, 2, 3);
      vt[11] = mk( 20, 0, 0, 0, 32'h0,        0,  1, 0, 20, 32'h11110002, 2, 3);
      // halt together with ack completes the fetch, applies in VALID
      vt[12] = mk( 20, 1, 0, 1, 32'h22220000, 0,  1, 0, 21, 32'h11110002, 2, 3);
      vt[13] = mk( 21, 1, 0, 0, 32'h0,        0,  0, 1, 21, 32'h22220000, 20, 3);
      vt[14] = mk( 21, 1, 0, 0, 32'h0,        1,  0, 1, 21, 32'h22220000, 20, 3);
      vt[15] = mk( 21, 0, 0, 0, 32'h0,        0,  0, 0, 21, 32'h22220000, 20, 4);
      vt[16] = mk( 21, 0, 0, 1, 32'h22220001, 0,  1, 0, 22, 32'h22220000, 20, 4);
      // redirect in VALID: no handshake even with decode_ready
      vt[17] = mk( 22, 0, 1, 0, 32'h0,        1,  0, 0, 22, 32'h22220001, 21, 4);
      vt[18] = mk( 30, 0, 0, 0, 32'h0,        0,  1, 0, 30, 32'h22220001, 21, 4);

      // Reset state
      #1 reset = 1'b1;
      #1;
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_count", {16'd0, instr_count}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
      step();
      #1 reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         drive(vt[i].pc, vt[i].hlt, vt[i].rdr, vt[i].ack, vt[i].rdata, vt[i].rdy);
         chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vt[i].eReq});
         chk($sformatf("v%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].eVal});
         chk($sformatf("v%0d_novo_pc_seq", i), novo_pc_seq, vt[i].eNovo);
         chk($sformatf("v%0d_instr", i), instr, vt[i].eInstr);
         chk($sformatf("v%0d_instr_pc", i), instr_pc, vt[i].eIpc);
         chk($sformatf("v%0d_count", i), {16'd0, instr_count}, {16'd0, vt[i].eCnt});
         if (vt[i].eReq) chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].pc);
         step();
      end

      // Delayed ack at pc 10: request held three cycles, PC holds
      for (int i = 0; i < 3; i++) begin
         drive(32'd10, 0, 0, 0, 32'h0, 0);
         chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
         chk("wait_mem_addr", mem_addr, 32'd10);
         chk("wait_novo_pc", novo_pc_seq, 32'd10);
         step();
      end
      drive(32'd10, 0, 0, 1, 32'h33330000, 0);
      chk("ack_novo_pc", novo_pc_seq, 32'd11);
      step();

      // Decode stalls four cycles: instruction held, counted once
      for (int i = 0; i < 4; i++) begin
         drive(32'd11, 0, 0, 0, 32'h0, 0);
         chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_instr", instr, 32'h33330000);
         chk("stall_instr_pc", instr_pc, 32'd10);
         chk("stall_count", {16'd0, instr_count}, 32'd4);
         step();
      end
      drive(32'd11, 0, 0, 0, 32'h0, 1);
      chk("stall_hs_valid", {31'd0, instr_valid}, 32'd1);
      step();
      drive(32'd11, 0, 0, 0, 32'h0, 0);
      chk("stall_count_after", {16'd0, instr_count}, 32'd5);
      chk("stall_back_to_req", {31'd0, mem_req}, 32'd1);

      // Counter wrap 0xFFFF -> 0x0000
      force dut.instr_count = 16'hFFFF;
      #1 release dut.instr_count;
      drive(32'd11, 0, 0, 1, 32'h44440000, 0);
      step();
      drive(32'd12, 0, 0, 0, 32'h0, 0);
      chk("wrap_pre_count", {16'd0, instr_count}, 32'h0000FFFF);
      chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
      drive(32'd12, 0, 0, 0, 32'h0, 1);
      step();
      drive(32'd12, 0, 0, 0, 32'h0, 0);
      chk("wrap_count", {16'd0, instr_count}, 32'd0);

      // Async reset mid-VALID
      drive(32'd12, 0, 0, 1, 32'h55550000, 0);
      step();
      drive(32'd13, 0, 0, 0, 32'h0, 1'b0);
      chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("async_rst_instr", instr, 32'd0);
      chk("async_rst_count", {16'd0, instr_count}, 32'd0);
      step();
      #1 reset = 1'b0;
      drive(32'd0, 0, 0, 0, 32'h0, 1);
      chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
      chk("post_rst_mem_addr", mem_addr, 32'd0);
      chk("post_rst_no_valid", {31'd0, instr_valid}, 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 The module SHALL have input clk, 1 bit: clock, all state on rising edge.
REQ-002 The module SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-003 The module SHALL have input pc_atual, 32 bits: current word address from the PC register.
REQ-004 The module SHALL have input halt, 1 bit: processor halted, so no new fetch.
REQ-005 The module SHALL have input redirect, 1 bit: branch/jump/context switch taken, so flush.
REQ-006 The module SHALL have output mem_req, 1 bit: instruction memory read request.
REQ-007 The module SHALL have output mem_addr, 32 bits: read word address.
REQ-008 The module SHALL have input mem_ack, 1 bit: mem_rdata valid this cycle.
REQ-009 The module SHALL have input mem_rdata, 32 bits: instruction word.
REQ-010 The module SHALL have output instr_valid, 1 bit: instr/instr_pc valid to decode.
REQ-011 The module SHALL have output instr, 32 bits: fetched instruction.
REQ-012 The module SHALL have output instr_pc, 32 bits: address instr was fetched from.
REQ-013 The module SHALL have input decode_ready, 1 bit: decode accepts instr this cycle.
REQ-014 The module SHALL have output novo_pc_seq, 32 bits: sequential next-PC candidate for the PC register mux.
REQ-015 The module SHALL have output instr_count, 16 bits: count of instructions handed to decode.

Function
REQ-016 The module SHALL implement states IDLE, REQ and VALID.
REQ-017 In IDLE, halt=0 SHALL move the module to REQ on the next edge.
REQ-018 In REQ, the module SHALL drive mem_req=1 and mem_addr=pc_atual combinationally.
REQ-019 In REQ with mem_ack=1 and redirect=0, the module SHALL capture instr<=mem_rdata and instr_pc<=pc_atual, then go to VALID.
REQ-020 novo_pc_seq SHALL equal pc_atual+1 (mod 2^32) only in a REQ cycle with mem_ack=1 and redirect=0, and SHALL equal pc_atual otherwise, so the PC holds.
REQ-021 mem_ack SHALL be accepted in the same cycle mem_req rises (zero-wait memory), and any later cycle.
REQ-022 In VALID, the module SHALL drive instr_valid=1, keep instr and instr_pc stable, and drive mem_req=0.
REQ-023 In VALID, decode_ready=1 SHALL increment instr_count (wrapping 0xFFFF to 0x0000), and the module SHALL go to REQ, or to IDLE if halt=1.
REQ-024 redirect=1 in any state SHALL take priority and move the module to REQ (IDLE if halt=1) on the next edge, with instr_valid=0 and instr_count unchanged.
REQ-025 A mem_ack coinciding with redirect SHALL be discarded.
REQ-026 In REQ, halt=1 without mem_ack SHALL move the module to IDLE and drop mem_req; the memory contract allows a request to be abandoned by deasserting mem_req.
REQ-027 In REQ, halt=1 together with mem_ack SHALL complete the fetch normally; halt then applies in VALID.
REQ-028 In IDLE, the module SHALL drive mem_req=0, instr_valid=0 and novo_pc_seq=pc_atual.
REQ-029 decode_ready outside VALID SHALL be ignored.

Reset
REQ-030 When reset=1, the module SHALL asynchronously set state=REQ, instr=0, instr_pc=0 and instr_count=0; instr_valid=0 as a consequence.
REQ-031 A reset asserted mid-fetch or in VALID SHALL discard the instruction with no decode handshake.
REQ-032 After reset deasserts, the first request SHALL be issued on the next cycle, at pc_atual (0 from the PC register).

Structure
REQ-033 The shared package SHALL hold the PC/instruction width constant (32), the count width (16) and the state enum.
REQ-034 The design SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-035 Verify: reset, pc_atual=0, mem_ack tied 1, decode_ready=1 -> fetches at 0,1,2,... every 2 cycles; instr_count increments each handshake.
REQ-036 Verify: mem_ack delayed 3 cycles at pc_atual=10 -> mem_req held 3 cycles, novo_pc_seq=10 then 11 on the ack cycle, instr_pc=10.
REQ-037 Verify: VALID with decode_ready=0 for 4 cycles -> instr stable and instr_valid=1 throughout; instr_count increments once.
REQ-038 Verify: redirect with mem_ack same cycle at pc_atual=20 -> data discarded, instr_valid stays 0, novo_pc_seq=20.
REQ-039 Verify: halt=1 in REQ without ack -> IDLE, mem_req=0; halt=0 -> REQ next cycle at held pc_atual.
REQ-040 Verify: instr_count=0xFFFF plus one handshake -> 0x0000; async reset mid-VALID -> instr_valid=0 immediately.
